mem_port_arbiter: RTL
=====================

Name:
mem_port_arbiter

Overview:
- Shares one single-port synchronous-read word RAM between the instruction-fetch port (read-only) and the load/store data port of the RISC-V core. Sits between the core and the unified memory for the multicycle/pipelined variants.
- Arbitration gives fixed priority to the data port, with a starvation counter that forces a fetch grant after MAX_WAIT denied cycles. Read responses are routed back to the requester that issued them.

Parameters:
ADDR_W, 10, word-address width
DATA_W, 32, data width; byte-enable width is DATA_W/8
MAX_WAIT, 4, consecutive denied fetch cycles before fetch wins; legal range is >=1

Ports:
CLK  in  1  clock; all state updates on the rising edge
RESET  in  1  synchronous, active-high reset
IF_REQ  in  1  fetch read request; held until IF_GNT
IF_ADDR  in  ADDR_W  fetch word address; stable while IF_REQ is high
IF_GNT  out  1  fetch request accepted this cycle (combinational)
IF_RVALID  out  1  IF_RDATA is valid; registered, one cycle after a fetch grant
IF_RDATA  out  DATA_W  fetch read data
DM_REQ  in  1  data request; held until DM_GNT
DM_WE  in  1  1 = write, 0 = read
DM_BE  in  DATA_W/8  write byte enables
DM_ADDR  in  ADDR_W  data word address
DM_WDATA  in  DATA_W  write data
DM_GNT  out  1  data request accepted this cycle (combinational)
DM_RVALID  out  1  DM_RDATA is valid; one cycle after a granted read
DM_RDATA  out  DATA_W  data read data
RAM_EN  out  1  RAM access this cycle
RAM_WE  out  1  RAM write
RAM_BE  out  DATA_W/8  RAM byte enables
RAM_ADDR  out  ADDR_W  RAM word address
RAM_WDATA  out  DATA_W  RAM write data
RAM_RDATA  in  DATA_W  RAM read data, valid one cycle after an enabled read

Behaviour:
- Reset (RESET=1 at a clock edge): WAIT_CNT=0, pending owner=NONE, IF_RVALID=DM_RVALID=0. While RESET is high, all GNT outputs and RAM_EN are forced to 0 regardless of the REQ inputs.
- Grant rule, evaluated every cycle:
  - If WAIT_CNT==MAX_WAIT and IF_REQ=1, grant IF.
  - Otherwise, if DM_REQ=1, grant DM.
  - Otherwise, if IF_REQ=1, grant IF.
  - At most one GNT is high in any cycle.
- RAM drive: RAM_EN=IF_GNT|DM_GNT, and the RAM address/data/enable signals come from the granted port.
  - On an IF grant: RAM_WE=0, RAM_BE=0.
  - With no grant: RAM_WE=0, RAM_BE=0, RAM_ADDR=0, RAM_WDATA=0.
- WAIT_CNT:
  - Increments (saturating at MAX_WAIT) when IF_REQ=1 and IF_GNT=0.
  - Clears when IF_GNT=1 or IF_REQ=0.
- Response routing: the pending owner register captures IF, or DM if DM_WE=0, at each read grant; otherwise it captures NONE. A granted write produces no RVALID.
  - The next cycle, the owner's RVALID=1.
  - IF_RDATA and DM_RDATA are both driven from RAM_RDATA and are meaningful only while the matching RVALID is high.
- Throughput: back-to-back grants every cycle are allowed. A read grant and the previous read's RVALID can coexist in the same cycle. Read-after-write to the same address in consecutive cycles returns the written data, since the RAM writes before that read.
- A write with DM_BE=0 is still granted and RAM_WE=1, so memory is unchanged.
- Reset mid-operation: a read granted in cycle n followed by RESET in cycle n+1 produces no RVALID.
- A requester dropping REQ before GNT is illegal; behaviour is undefined, and the bench flags it with an assertion.

Decomposition:
- Package riscv_mem_pkg holds ADDR_W/DATA_W defaults, the owner_t enum {OWN_NONE, OWN_IF, OWN_DM}, and a BE_W constant.
- Single module; no sub-module is warranted.

Test Plan:
- Reset: RESET=1 for 2 cycles with IF_REQ=DM_REQ=1 -> both GNT=0, RAM_EN=0, both RVALID=0. First cycle after RESET falls -> DM_GNT=1.
- Fetch only: IF_ADDR=0x010 with the RAM preloaded with 0x00500093 -> IF_GNT=1 the same cycle, RAM_ADDR=0x010. Next cycle IF_RVALID=1, IF_RDATA=0x00500093, DM_RVALID=0.
- Conflict: both request; DM writes 0x020 with 0xDEADBEEF, BE=4'hF -> DM_GNT=1, IF_GNT=0. Next cycle IF_GNT=1 and no DM_RVALID.
- Starvation: DM_REQ reads and IF_REQ both held high, MAX_WAIT=4 -> DM granted for 4 cycles, IF granted in the 5th, DM granted in the 6th.
- Byte-enable RAW: write 0x020 = 0x0000CAFE with BE=4'b0011 over 0xDEADBEEF, then read 0x020 the next cycle -> DM_RVALID=1, DM_RDATA=0xDEADCAFE.
- Reset mid-read: DM read granted in cycle n, RESET=1 in cycle n+1 -> DM_RVALID=0 in n+1 and n+2, WAIT_CNT=0.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types and default widths for the core-to-unified-memory port arbiter.
package riscv_mem_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int BE_W       = DEF_DATA_W / 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous-read RAM between instruction fetch and the
// load/store port: data has priority, fetch is forced through after MAX_WAIT denials.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  IF_REQ,
  input  logic [ADDR_W-1:0]     IF_ADDR,
  output logic                  IF_GNT,
  output logic                  IF_RVALID,
  output logic [DATA_W-1:0]     IF_RDATA,
  input  logic                  DM_REQ,
  input  logic                  DM_WE,
  input  logic [DATA_W/8-1:0]   DM_BE,
  input  logic [ADDR_W-1:0]     DM_ADDR,
  input  logic [DATA_W-1:0]     DM_WDATA,
  output logic                  DM_GNT,
  output logic                  DM_RVALID,
  output logic [DATA_W-1:0]     DM_RDATA,
  output logic                  RAM_EN,
  output logic                  RAM_WE,
  output logic [DATA_W/8-1:0]   RAM_BE,
  output logic [ADDR_W-1:0]     RAM_ADDR,
  output logic [DATA_W-1:0]     RAM_WDATA,
  input  logic [DATA_W-1:0]     RAM_RDATA
);

  localparam int               CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_r;
  logic [CNT_W-1:0] wait_cnt_nxt_s;
  owner_t           owner_r;
  owner_t           owner_nxt_s;
  logic             starve_s;
  logic             if_gnt_s;
  logic             dm_gnt_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == WAIT_MAX) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  assign starve_s = (wait_cnt_r == WAIT_MAX) && IF_REQ;

  // Fixed-priority grant with the starvation override for fetch
  always_comb begin
    if_gnt_s = 1'b0;
    dm_gnt_s = 1'b0;
    if (RESET) begin
      if_gnt_s = 1'b0;
      dm_gnt_s = 1'b0;
    end else if (starve_s) begin
      if_gnt_s = 1'b1;
    end else if (DM_REQ) begin
      dm_gnt_s = 1'b1;
    end else if (IF_REQ) begin
      if_gnt_s = 1'b1;
    end else begin
      if_gnt_s = 1'b0;
      dm_gnt_s = 1'b0;
    end
  end

  // RAM command mux; idle cycles drive all-zero so the bus is quiet
  always_comb begin
    RAM_EN    = 1'b0;
    RAM_WE    = 1'b0;
    RAM_BE    = '0;
    RAM_ADDR  = '0;
    RAM_WDATA = '0;
    case ({if_gnt_s, dm_gnt_s})
      2'b10: begin
        RAM_EN   = 1'b1;
        RAM_ADDR = IF_ADDR;
      end
      2'b01: begin
        RAM_EN    = 1'b1;
        RAM_WE    = DM_WE;
        RAM_BE    = DM_BE;
        RAM_ADDR  = DM_ADDR;
        RAM_WDATA = DM_WDATA;
      end
      default: begin
        RAM_EN    = 1'b0;
        RAM_WE    = 1'b0;
        RAM_BE    = '0;
        RAM_ADDR  = '0;
        RAM_WDATA = '0;
      end
    endcase
  end

  // Next starvation count and next owner of the in-flight read
  always_comb begin
    wait_cnt_nxt_s = '0;
    owner_nxt_s    = OWN_NONE;
    if (IF_REQ && !if_gnt_s) begin
      wait_cnt_nxt_s = sat_inc(wait_cnt_r);
    end else begin
      wait_cnt_nxt_s = '0;
    end
    if (if_gnt_s) begin
      owner_nxt_s = OWN_IF;
    end else if (dm_gnt_s && !DM_WE) begin
      owner_nxt_s = OWN_DM;
    end else begin
      owner_nxt_s = OWN_NONE;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wait_cnt_r <= '0;
      owner_r    <= OWN_NONE;
    end else begin
      wait_cnt_r <= wait_cnt_nxt_s;
      owner_r    <= owner_nxt_s;
    end
  end

  // RESET masks a response already in flight so a read cut off by reset never reports valid
  assign IF_RVALID = (owner_r == OWN_IF) && !RESET;
  assign DM_RVALID = (owner_r == OWN_DM) && !RESET;
  assign IF_RDATA  = RAM_RDATA;
  assign DM_RDATA  = RAM_RDATA;
  assign IF_GNT    = if_gnt_s;
  assign DM_GNT    = dm_gnt_s;

endmodule
